id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and EX-stage operand front end that feeds the ALU directly. Captures decoded operands and control each cycle and applies EX/MEM and MEM/WB forwarding to produce `alu_op1`, `alu_op2` and `alu_sel`. Detects load-use hazards and inserts bubbles. Honours external stall and flush requests.

## Interface
- `WIDTH`, 32, datapath width; must match the ALU `width`.
- `RADDR`, 5, register-address width.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst` in 1 — reset, asynchronous and active-high.
- `stall` in 1 — hold the stage contents; from downstream or the hazard unit.
- `flush` in 1 — replace the captured instruction with a bubble (branch redirect).
- `id_valid` in 1 — the ID stage holds a real instruction.
- `id_rs1`, `id_rs2` in RADDR — source register numbers.
- `id_rd` in RADDR — destination register number.
- `id_rs1_data`, `id_rs2_data` in WIDTH — register-file read data.
- `id_imm` in WIDTH — sign-extended immediate.
- `id_alu_sel` in 4 — ALU opcode, using the shared encoding.
- `id_use_imm` in 1 — when set, `alu_op2` is the immediate.
- `id_ctrl` in 3 — control bits `{reg_write, mem_read, mem_write}`.
- `exmem_rd` in RADDR, `exmem_reg_write` in 1, `exmem_result` in WIDTH — EX/MEM forwarding source.
- `memwb_rd` in RADDR, `memwb_reg_write` in 1, `memwb_result` in WIDTH — MEM/WB forwarding source.
- `ex_valid` out 1 — the EX stage holds a real instruction.
- `alu_op1`, `alu_op2` out WIDTH — operands after forwarding; connect to the ALU `op1` and `op2` inputs.
- `alu_sel` out 4 — registered opcode; connect to the ALU `sel` input.
- `ex_rd` out RADDR, `ex_ctrl` out 3 — registered destination and control.
- `ex_store_data` out WIDTH — forwarded rs2 value, used by stores.
- `load_use_stall` out 1 — combinational; upstream holds PC and IF/ID while it is high.

## Operation
- **Per-edge priority:** `rst` > `flush` > `stall` > `load_use_stall` > capture.
- **Bubble:** `ex_valid`=0, `ex_ctrl`=0, `alu_sel`=4'b0000 (AND), `ex_rd`=0. Operand registers are cleared.
- **Capture:** all `id_*` fields are registered. `ex_valid` takes `id_valid`.
- **Stall (hold):** control, `ex_rd` and `alu_sel` hold. The rs1/rs2 data registers reload with the current forwarded values, so a MEM/WB write-back that arrives during the stall is not lost.
- **Forwarding, per source `s` in {rs1, rs2}:**
  - Use `exmem_result` if `exmem_reg_write` is set, `exmem_rd`==`s`, and `s`!=0.
  - Otherwise use `memwb_result` under the same conditions with the MEM/WB fields.
  - Otherwise use the registered data.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- **Operand select:** `alu_op1` = fwd(rs1). `alu_op2` = `use_imm` ? imm : fwd(rs2). `ex_store_data` = fwd(rs2).
- **Load-use stall:** `load_use_stall` is high when all of the following hold:
  - `ex_valid` is set, `ex_ctrl.mem_read` is set, and `ex_rd`!=0;
  - `id_valid` is set;
  - `ex_rd` equals `id_rs1`, or `ex_rd` equals `id_rs2` while rs2 is used.
  - rs2 counts as used when `!id_use_imm` or `id_mem_write`.
  - It is forced to 0 while `flush` is high.
- **Width rules:** all data is WIDTH bits and passes through unchanged. The block performs no arithmetic.

## Timing
- **Reset:** every output is 0, and `load_use_stall` evaluates to 0. Asserting `rst` mid-operation clears outputs asynchronously, without waiting for an edge.
- **Latency:** `id_*` to `ex_*`/`alu_sel` is 1 cycle. The forwarding inputs reach `alu_op1`/`alu_op2` combinationally in the same cycle, so the ALU result is valid before the next edge.
- **Load-use sequence:** `load_use_stall` rises in the cycle the dependent instruction sits in ID.
  - Next edge: EX receives a bubble and the load moves to EX/MEM.
  - The following cycle: the stall drops and the dependent instruction is captured, then takes the load data from `memwb_result`.
- **Simultaneous `stall` and hazard:** hold wins and no bubble is inserted. The hazard re-evaluates next cycle.
- **Simultaneous `flush` and `stall`:** a bubble is inserted.

## Structure
- **Shared package `pipe_pkg`:**
  - ALU opcode constants: AND 0000, OR 0001, ADD 0010, ANDNOT 0100, ORNOT 0101, SUB 0110, SLT 0111, XOR 1000, SLL 1001, SRL 1010, SRA 1011, MULT 1100.
  - `id_ctrl` bit positions.
  - The bubble control value.
- **Sub-module `operand_forward`:** a combinational 3-way priority mux, instantiated once for rs1 and once for rs2.

## Test plan
- **Reset mid-operation:** stage holds a valid ADD, then `rst` is pulsed between edges → all outputs 0 immediately.
- **Plain capture:** rs1_data=5, rs2_data=7, sel=0010, rd=3 → next cycle `alu_op1`=5, `alu_op2`=7, `alu_sel`=0010, `ex_rd`=3, `ex_valid`=1.
- **Forward priority:** registered rs1=4, exmem(rd=4, result=0x11), memwb(rd=4, result=0x22) → `alu_op1`=0x11.
  - Clear `exmem_reg_write` → 0x22.
  - Set rs1=0 with both rd=0 → raw register data.
- **Load-use:** EX holds a load with rd=6; ID has rs2=6 and use_imm=0.
  - → `load_use_stall`=1; next cycle `ex_valid`=0 and `ex_ctrl`=0.
  - Repeat with use_imm=1 and no store → `load_use_stall`=0.
- **Stall refresh:** `stall` held for 3 cycles; memwb forwards rs1 value 0x33 in the first cycle only → `alu_op1` stays 0x33 for all 3 cycles.
- **Flush with stall:** `flush` and `stall` asserted together with a load-use hazard present → bubble captured, and `load_use_stall`=0 while `flush` is high.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcode encoding, id_ctrl bit layout and bubble control.
package pipe_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_ANDNOT = 4'b0100;
  localparam logic [3:0] ALU_ORNOT  = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_XOR    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b1001;
  localparam logic [3:0] ALU_SRL    = 4'b1010;
  localparam logic [3:0] ALU_SRA    = 4'b1011;
  localparam logic [3:0] ALU_MULT   = 4'b1100;

  // id_ctrl = {reg_write, mem_read, mem_write}
  localparam int unsigned CTRL_REG_WRITE = 2;
  localparam int unsigned CTRL_MEM_READ  = 1;
  localparam int unsigned CTRL_MEM_WRITE = 0;

  localparam logic [2:0] CTRL_BUBBLE = 3'b000;

endpackage

// File: rtl/operand_forward.sv
// Three-way operand priority mux: EX/MEM result, then MEM/WB result, then register data.
module operand_forward #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic [RADDR-1:0] i_rs,
  input  logic [WIDTH-1:0] i_reg_data,
  input  logic [RADDR-1:0] i_exmem_rd,
  input  logic             i_exmem_reg_write,
  input  logic [WIDTH-1:0] i_exmem_result,
  input  logic [RADDR-1:0] i_memwb_rd,
  input  logic             i_memwb_reg_write,
  input  logic [WIDTH-1:0] i_memwb_result,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_reg_data;
    if (i_rs != '0) begin
      if (i_exmem_reg_write && (i_exmem_rd == i_rs)) begin
        o_data = i_exmem_result;
      end else if (i_memwb_reg_write && (i_memwb_rd == i_rs)) begin
        o_data = i_memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use detection,
// external stall (hold with operand refresh) and flush (bubble insertion).
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [3:0]       id_alu_sel,
  input  logic             id_use_imm,
  input  logic [2:0]       id_ctrl,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             memwb_reg_write,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [3:0]       alu_sel,
  output logic [RADDR-1:0] ex_rd,
  output logic [2:0]       ex_ctrl,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             load_use_stall
);

  logic             r_valid;
  logic [2:0]       r_ctrl;
  logic [RADDR-1:0] r_rd;
  logic [3:0]       r_sel;
  logic [RADDR-1:0] r_rs1;
  logic [RADDR-1:0] r_rs2;
  logic [WIDTH-1:0] r_rs1_data;
  logic [WIDTH-1:0] r_rs2_data;
  logic [WIDTH-1:0] r_imm;
  logic             r_use_imm;

  logic [WIDTH-1:0] w_fwd1;
  logic [WIDTH-1:0] w_fwd2;
  logic             w_rs2_used;
  logic             w_load_use;

  operand_forward #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs1 (
    .i_rs              (r_rs1),
    .i_reg_data        (r_rs1_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd1)
  );

  operand_forward #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs2 (
    .i_rs              (r_rs2),
    .i_reg_data        (r_rs2_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd2)
  );

  always_comb begin
    w_rs2_used = !id_use_imm || id_ctrl[CTRL_MEM_WRITE];
    w_load_use = !flush && r_valid && r_ctrl[CTRL_MEM_READ] && (r_rd != '0) && id_valid &&
                 ((r_rd == id_rs1) || ((r_rd == id_rs2) && w_rs2_used));
  end

  // Stall holds control but reloads operand data from the forwarded values so a
  // write-back landing during the stall survives once the forwarding source moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_BUBBLE;
      r_rd       <= '0;
      r_sel      <= ALU_AND;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
    end else if (flush || (!stall && w_load_use)) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_BUBBLE;
      r_rd       <= '0;
      r_sel      <= ALU_AND;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
    end else if (stall) begin
      r_rs1_data <= w_fwd1;
      r_rs2_data <= w_fwd2;
    end else begin
      r_valid    <= id_valid;
      r_ctrl     <= id_ctrl;
      r_rd       <= id_rd;
      r_sel      <= id_alu_sel;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_use_imm  <= id_use_imm;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_ctrl        = r_ctrl;
  assign ex_rd          = r_rd;
  assign alu_sel        = r_sel;
  assign alu_op1        = w_fwd1;
  assign alu_op2        = r_use_imm ? r_imm : w_fwd2;
  assign ex_store_data  = w_fwd2;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, forwarding,
// load-use, stall refresh and flush interactions.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_sel;
  logic        id_use_imm;
  logic [2:0]  id_ctrl;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_sel;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ctrl;
  logic [31:0] ex_store_data;
  logic        load_use_stall;

  int checks;
  int failures;

  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_alu_sel      (id_alu_sel),
    .id_use_imm      (id_use_imm),
    .id_ctrl         (id_ctrl),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .alu_op1         (alu_op1),
    .alu_op2         (alu_op2),
    .alu_sel         (alu_sel),
    .ex_rd           (ex_rd),
    .ex_ctrl         (ex_ctrl),
    .ex_store_data   (ex_store_data),
    .load_use_stall  (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    stall = 0; flush = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_alu_sel = 0; id_use_imm = 0; id_ctrl = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [3:0] sel, input logic use_imm, input logic [2:0] ctrl);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alu_sel = sel; id_use_imm = use_imm; id_ctrl = ctrl;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    #2;
    checks++; if ({ex_valid, alu_op1, alu_op2, alu_sel, ex_rd, ex_ctrl, ex_store_data, load_use_stall} !== '0) begin
      failures++; $display("FAIL reset_outputs got_valid=%b op1=%h op2=%h sel=%h rd=%0d ctrl=%b lus=%b exp all 0",
                           ex_valid, alu_op1, alu_op2, alu_sel, ex_rd, ex_ctrl, load_use_stall);
    end
    step();
    rst = 0;
    drive_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 3'b100);
    step();
    checks++; if (ex_valid !== 1'b1) begin
      failures++; $display("FAIL pre_midreset_valid got=%b exp=1", ex_valid);
    end
    #2 rst = 1;
    #1;
    checks++; if ({ex_valid, alu_op1, alu_op2, alu_sel, ex_rd, ex_ctrl, ex_store_data, load_use_stall} !== '0) begin
      failures++; $display("FAIL midreset_outputs got_valid=%b op1=%h op2=%h sel=%h rd=%0d ctrl=%b exp all 0",
                           ex_valid, alu_op1, alu_op2, alu_sel, ex_rd, ex_ctrl);
    end
    #1 rst = 0;
    drive_idle();
    step();
  endtask

  task automatic test_capture();
    drive_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 3'b100);
    step();
    checks++; if (alu_op1 !== 32'd5) begin failures++; $display("FAIL cap_op1 got=%h exp=%h", alu_op1, 32'd5); end
    checks++; if (alu_op2 !== 32'd7) begin failures++; $display("FAIL cap_op2 got=%h exp=%h", alu_op2, 32'd7); end
    checks++; if (alu_sel !== 4'b0010) begin failures++; $display("FAIL cap_sel got=%b exp=0010", alu_sel); end
    checks++; if (ex_rd !== 5'd3) begin failures++; $display("FAIL cap_rd got=%0d exp=3", ex_rd); end
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%b exp=1", ex_valid); end
    checks++; if (ex_ctrl !== 3'b100) begin failures++; $display("FAIL cap_ctrl got=%b exp=100", ex_ctrl); end
    checks++; if (ex_store_data !== 32'd7) begin failures++; $display("FAIL cap_store got=%h exp=%h", ex_store_data, 32'd7); end
    drive_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h40, 4'b0110, 1'b1, 3'b100);
    step();
    checks++; if (alu_op2 !== 32'h40) begin failures++; $display("FAIL cap_imm_op2 got=%h exp=%h", alu_op2, 32'h40); end
    checks++; if (alu_sel !== 4'b0110) begin failures++; $display("FAIL cap_imm_sel got=%b exp=0110", alu_sel); end
    drive_idle();
    step();
  endtask

  task automatic test_forward();
    drive_instr(5'd4, 5'd5, 5'd8, 32'hAA, 32'hBB, 32'd0, 4'b0010, 1'b0, 3'b100);
    step();
    id_valid = 0;
    exmem_rd = 5'd4; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 5'd4; memwb_reg_write = 1; memwb_result = 32'h22;
    #1;
    checks++; if (alu_op1 !== 32'h11) begin failures++; $display("FAIL fwd_exmem got=%h exp=%h", alu_op1, 32'h11); end
    checks++; if (alu_op2 !== 32'hBB) begin failures++; $display("FAIL fwd_rs2_untouched got=%h exp=%h", alu_op2, 32'hBB); end
    exmem_reg_write = 0;
    #1;
    checks++; if (alu_op1 !== 32'h22) begin failures++; $display("FAIL fwd_memwb got=%h exp=%h", alu_op1, 32'h22); end
    memwb_reg_write = 0;
    #1;
    checks++; if (alu_op1 !== 32'hAA) begin failures++; $display("FAIL fwd_none got=%h exp=%h", alu_op1, 32'hAA); end
    memwb_rd = 5'd5; memwb_reg_write = 1; memwb_result = 32'h77;
    #1;
    checks++; if (ex_store_data !== 32'h77) begin failures++; $display("FAIL fwd_store got=%h exp=%h", ex_store_data, 32'h77); end
    checks++; if (alu_op2 !== 32'h77) begin failures++; $display("FAIL fwd_op2 got=%h exp=%h", alu_op2, 32'h77); end
    drive_idle();
    drive_instr(5'd0, 5'd5, 5'd8, 32'h5A, 32'hBB, 32'h1234, 4'b0010, 1'b1, 3'b100);
    step();
    id_valid = 0;
    exmem_rd = 5'd0; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 5'd0; memwb_reg_write = 1; memwb_result = 32'h22;
    #1;
    checks++; if (alu_op1 !== 32'h5A) begin failures++; $display("FAIL fwd_r0 got=%h exp=%h", alu_op1, 32'h5A); end
    memwb_rd = 5'd5; memwb_result = 32'h99;
    #1;
    checks++; if (alu_op2 !== 32'h1234) begin failures++; $display("FAIL fwd_imm_wins got=%h exp=%h", alu_op2, 32'h1234); end
    checks++; if (ex_store_data !== 32'h99) begin failures++; $display("FAIL fwd_imm_store got=%h exp=%h", ex_store_data, 32'h99); end
    drive_idle();
    step();
  endtask

  task automatic test_load_use();
    drive_instr(5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 32'd8, 4'b0010, 1'b1, 3'b110);
    step();
    drive_instr(5'd2, 5'd6, 5'd7, 32'h1, 32'h2, 32'd0, 4'b0010, 1'b0, 3'b100);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_detect got=%b exp=1", load_use_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_ctrl !== 3'b000) begin failures++; $display("FAIL lu_bubble_ctrl got=%b exp=000", ex_ctrl); end
    checks++; if (ex_rd !== 5'd0) begin failures++; $display("FAIL lu_bubble_rd got=%0d exp=0", ex_rd); end
    checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", load_use_stall); end
    step();
    memwb_rd = 5'd6; memwb_reg_write = 1; memwb_result = 32'h99;
    #1;
    checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin failures++; $display("FAIL lu_dep_capture got=%b/%0d exp=1/7", ex_valid, ex_rd); end
    checks++; if (alu_op2 !== 32'h99) begin failures++; $display("FAIL lu_dep_fwd got=%h exp=%h", alu_op2, 32'h99); end
    drive_idle();
    drive_instr(5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 32'd8, 4'b0010, 1'b1, 3'b110);
    step();
    drive_instr(5'd2, 5'd6, 5'd7, 32'h1, 32'h2, 32'd4, 4'b0010, 1'b1, 3'b100);
    #1;
    checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_imm_nostall got=%b exp=0", load_use_stall); end
    id_ctrl = 3'b001;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_store_rs2 got=%b exp=1", load_use_stall); end
    id_ctrl = 3'b100; id_rs1 = 5'd6;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_rs1 got=%b exp=1", load_use_stall); end
    id_valid = 0;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_id_invalid got=%b exp=0", load_use_stall); end
    drive_idle();
    step();
  endtask

  task automatic test_stall_refresh();
    drive_instr(5'd9, 5'd0, 5'd4, 32'h10, 32'h0, 32'd0, 4'b0001, 1'b0, 3'b100);
    step();
    drive_instr(5'd3, 5'd0, 5'd12, 32'hEE, 32'h0, 32'd0, 4'b1000, 1'b0, 3'b100);
    stall = 1;
    memwb_rd = 5'd9; memwb_reg_write = 1; memwb_result = 32'h33;
    #1;
    checks++; if (alu_op1 !== 32'h33) begin failures++; $display("FAIL stall_c1_op1 got=%h exp=%h", alu_op1, 32'h33); end
    step();
    memwb_reg_write = 0; memwb_result = 32'h0;
    #1;
    checks++; if (alu_op1 !== 32'h33) begin failures++; $display("FAIL stall_c2_op1 got=%h exp=%h", alu_op1, 32'h33); end
    checks++; if ({alu_sel, ex_rd} !== {4'b0001, 5'd4}) begin failures++; $display("FAIL stall_hold got=%b/%0d exp=0001/4", alu_sel, ex_rd); end
    step();
    checks++; if (alu_op1 !== 32'h33) begin failures++; $display("FAIL stall_c3_op1 got=%h exp=%h", alu_op1, 32'h33); end
    stall = 0;
    step();
    checks++; if ({alu_op1, ex_rd, alu_sel} !== {32'hEE, 5'd12, 4'b1000}) begin
      failures++; $display("FAIL stall_release got=%h/%0d/%b exp=ee/12/1000", alu_op1, ex_rd, alu_sel);
    end
    drive_idle();
    step();
  endtask

  task automatic test_flush_stall();
    drive_instr(5'd1, 5'd0, 5'd6, 32'h3, 32'd0, 32'd8, 4'b0010, 1'b1, 3'b110);
    step();
    drive_instr(5'd6, 5'd0, 5'd7, 32'h1, 32'h2, 32'd0, 4'b0010, 1'b1, 3'b100);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL fl_pre_hazard got=%b exp=1", load_use_stall); end
    flush = 1; stall = 1;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL fl_lus_forced got=%b exp=0", load_use_stall); end
    step();
    checks++; if ({ex_valid, ex_ctrl, ex_rd, alu_sel} !== '0) begin
      failures++; $display("FAIL fl_bubble got=%b/%b/%0d/%b exp=0/000/0/0000", ex_valid, ex_ctrl, ex_rd, alu_sel);
    end
    checks++; if (alu_op1 !== 32'h0) begin failures++; $display("FAIL fl_op_clear got=%h exp=0", alu_op1); end
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive_instr(5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 32'd8, 4'b0010, 1'b1, 3'b110);
    step();
    drive_instr(5'd6, 5'd0, 5'd7, 32'h1, 32'h2, 32'd0, 4'b0001, 1'b1, 3'b100);
    stall = 1;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL b2b_hazard_under_stall got=%b exp=1", load_use_stall); end
    step();
    checks++; if ({ex_valid, ex_ctrl, ex_rd} !== {1'b1, 3'b110, 5'd6}) begin
      failures++; $display("FAIL b2b_hold_wins got=%b/%b/%0d exp=1/110/6", ex_valid, ex_ctrl, ex_rd);
    end
    stall = 0;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL b2b_reeval got=%b exp=1", load_use_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL b2b_bubble got=%b exp=0", ex_valid); end
    step();
    checks++; if ({ex_valid, ex_rd, alu_sel} !== {1'b1, 5'd7, 4'b0001}) begin
      failures++; $display("FAIL b2b_dep got=%b/%0d/%b exp=1/7/0001", ex_valid, ex_rd, alu_sel);
    end
    drive_idle();
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_stall_refresh();
    test_flush_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
